layer0_input_packer: RTL and testbench

Upstream feeder for the first LogicNets layer of the readout network. It accepts a serial stream of signed readout features, one per beat, and quantizes each to 1 bit against a per-feature threshold. It packs a full frame into an N_FEAT-bit vector and presents it with valid/ready to the layer0 neuron array, which wires 6-bit fan-in slices of the vector into its LUT neurons. Malformed frames are dropped and flagged.

---
 rtl/layer0_input_packer.sv | 138 +++++++++++++
 tb/tb_layer0_input_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_input_packer.sv
// Purpose: quantize a serial stream of signed features to 1 bit each and pack one frame into an N_FEAT-bit vector.
// Latency: the vector is valid the cycle after its last beat is accepted; full frames stream back-to-back with no bubbles.
// Backpressure: one output register plus one held vector; while a vector waits in hold, s_ready drops.
//
// Ports:
//   clk, rst_n                  rising-edge clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last  input feature beats (signed IN_W), s_last marks the frame end
//   m_valid/m_ready/m_data      packed vector to layer0, bit k = feature k
//   frame_err                   one-cycle pulse per dropped (short or long) frame
module layer0_input_packer #(
    parameter int N_FEAT = 16,
    parameter int IN_W   = 12,
    parameter logic [N_FEAT*IN_W-1:0] THRESH = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_FEAT-1:0]      m_data,
    output logic                   frame_err
);

    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_FEAT - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [IW-1:0]       idx, idx_d;
    logic [N_FEAT-1:0]   asm_q, asm_d;
    logic [N_FEAT-1:0]   full_vec;
    logic                mvld_d;
    logic [N_FEAT-1:0]   mdat_d;
    logic                ferr_d;
    logic                qbit;
    logic                acc;
    logic                slot_free;
    logic                last_idx;

    // Per-feature thresholds unpacked once so the compare sees a plain signed value.
    logic signed [IN_W-1:0] thr_tab [N_FEAT];
    for (genvar k = 0; k < N_FEAT; k++) begin : g_thr
        assign thr_tab[k] = THRESH[k*IN_W +: IN_W];
    end

    assign s_ready   = rst_n && (state != HOLD);
    assign acc       = s_valid && s_ready;
    assign qbit      = (s_data >= thr_tab[idx]);
    assign last_idx  = (idx == LAST_IDX);
    // The output register can take a new vector if it is empty or being drained this edge.
    assign slot_free = !m_valid || m_ready;

    // Assembly contents with the current beat's bit merged in.
    always_comb begin
        full_vec      = asm_q;
        full_vec[idx] = qbit;
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        asm_d   = asm_q;
        mvld_d  = m_valid && !m_ready;
        mdat_d  = m_data;
        ferr_d  = 1'b0;
        case (state)
            COLLECT: begin
                if (acc) begin
                    asm_d = full_vec;
                    if (!s_last && !last_idx) begin
                        idx_d = idx + 1'b1;
                    end else if (s_last && last_idx) begin
                        idx_d = '0;
                        if (slot_free) begin
                            mvld_d = 1'b1;
                            mdat_d = full_vec;
                        end else begin
                            // Completed vector parks in asm_q until the output drains.
                            state_d = HOLD;
                        end
                    end else if (s_last) begin
                        idx_d  = '0;
                        ferr_d = 1'b1;
                    end else begin
                        // Frame overran N_FEAT beats: flag once, swallow the rest.
                        idx_d   = '0;
                        ferr_d  = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            HOLD: begin
                if (m_valid && m_ready) begin
                    mvld_d  = 1'b1;
                    mdat_d  = asm_q;
                    state_d = COLLECT;
                end
            end
            DISCARD: begin
                if (acc && s_last) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            asm_q     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            asm_q     <= asm_d;
            m_valid   <= mvld_d;
            m_data    <= mdat_d;
            frame_err <= ferr_d;
        end
    end

endmodule

// File: tb/tb_layer0_input_packer.sv
module tb_layer0_input_packer;
    localparam int N = 4;
    localparam int W = 8;
    // Thresholds k=0..3: 0, 16, -16, 100
    localparam logic [N*W-1:0] TH = {8'h64, 8'hF0, 8'h10, 8'h00};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic signed [W-1:0] s_data = '0;
    logic s_ready, m_valid, frame_err;
    logic [N-1:0] m_data;

    always #5 clk = ~clk;

    layer0_input_packer #(.N_FEAT(N), .IN_W(W), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .frame_err(frame_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_cnt = 0;
    int out_cnt = 0;
    logic [N-1:0] last_out = '0;
    bit rand_mr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frames are the beats between s_last marks; a frame of exactly N beats yields
    // a vector, anything else is dropped with one error. At most two finished
    // vectors can be outstanding (output slot + held one); input stalls at two.
    int thr [N] = '{0, 16, -16, 100};
    logic [N-1:0] q [$];
    int flen = 0;
    logic [N-1:0] fvec = '0;
    logic err_exp = 1'b0;
    bit started = 0;
    bit m_acc, m_hs;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            flen = 0;
            fvec = '0;
            err_exp = 1'b0;
            started = 1;
        end else begin
            m_acc = s_valid && (q.size() < 2);
            m_hs = (q.size() > 0) && m_ready;
            err_exp = 1'b0;
            if (m_hs) void'(q.pop_front());
            if (m_acc) begin
                flen++;
                if (flen <= N) fvec[flen-1] = (int'(s_data) >= thr[flen-1]);
                if (s_last) begin
                    if (flen == N) q.push_back(fvec);
                    else if (flen < N) err_exp = 1'b1;
                    flen = 0;
                end else if (flen == N) begin
                    err_exp = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("s_ready", {31'd0, s_ready}, {31'd0, rst_n && (q.size() < 2)});
            chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) chk("m_data", {28'd0, m_data}, {28'd0, q[0]});
            chk("frame_err", {31'd0, frame_err}, {31'd0, err_exp});
            if (frame_err === 1'b1) err_cnt++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                out_cnt++;
                last_out = m_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mr) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic beat(input int d, input bit l);
        bit got = 0;
        bit seen;
        s_valid = 1'b1;
        s_data = d[W-1:0];
        s_last = l;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            seen = s_ready;
            #1;
            if (rand_mr) m_ready = 1'($urandom_range(0, 1));
            if (seen) begin
                got = 1;
                break;
            end
        end
        s_valid = 1'b0;
        s_data = W'($urandom);
        s_last = 1'($urandom);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL beat_timeout: beat %0d not accepted within 200 cycles", d);
        end
    endtask

    task automatic send(input int v [8], input int n);
        for (int i = 0; i < n; i++) beat(v[i], i == n - 1);
    endtask

    int e0, o0, c0;
    int rv [8];
    int len;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk("rst m_valid", {31'd0, m_valid}, 0);
        chk("rst m_data", {28'd0, m_data}, 0);
        chk("rst frame_err", {31'd0, frame_err}, 0);
        chk("rst s_ready", {31'd0, s_ready}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        idle(2);

        // 1: basic frame
        o0 = out_cnt;
        send('{5, 16, -17, 99, 0, 0, 0, 0}, 4);
        idle(3);
        chk("t1 count", out_cnt - o0, 1);
        chk("t1 data", {28'd0, last_out}, 32'b0011);

        // 2: extremes and equality (bit k = feature k)
        send('{-128, 127, -16, 100, 0, 0, 0, 0}, 4);
        idle(3);
        chk("t2 data", {28'd0, last_out}, 32'b1110);

        // 3: backpressure, two frames queued
        m_ready = 1'b0;
        send('{0, 0, -100, 0, 0, 0, 0, 0}, 4);
        send('{-1, 0, -100, 100, 0, 0, 0, 0}, 4);
        @(negedge clk);
        chk("t3 hold s_ready", {31'd0, s_ready}, 0);
        chk("t3 hold m_data", {28'd0, m_data}, 32'b0001);
        idle(2);
        @(negedge clk);
        chk("t3 still held", {28'd0, m_data}, 32'b0001);
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        chk("t3 B m_data", {28'd0, m_data}, 32'b1000);
        chk("t3 B s_ready", {31'd0, s_ready}, 1);
        m_ready = 1'b1;
        idle(2);

        // 4: short frame then good frame
        e0 = err_cnt; o0 = out_cnt;
        send('{7, 7, 0, 0, 0, 0, 0, 0}, 2);
        idle(2);
        chk("t4 err", err_cnt - e0, 1);
        chk("t4 no out", out_cnt - o0, 0);
        send('{5, 16, -17, 99, 0, 0, 0, 0}, 4);
        idle(3);
        chk("t4 data", {28'd0, last_out}, 32'b0011);

        // 5: long frame then good frame
        e0 = err_cnt; o0 = out_cnt;
        send('{1, 2, 3, 4, 5, 6, 0, 0}, 6);
        idle(2);
        chk("t5 err", err_cnt - e0, 1);
        chk("t5 no out", out_cnt - o0, 0);
        send('{-128, 127, -16, 100, 0, 0, 0, 0}, 4);
        idle(3);
        chk("t5 data", {28'd0, last_out}, 32'b1110);

        // 6: reset mid-frame
        e0 = err_cnt; o0 = out_cnt;
        beat(50, 0);
        beat(50, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6 m_valid", {31'd0, m_valid}, 0);
        chk("t6 frame_err", {31'd0, frame_err}, 0);
        send('{0, 0, -100, 0, 0, 0, 0, 0}, 4);
        idle(3);
        chk("t6 err", err_cnt - e0, 0);
        chk("t6 out", out_cnt - o0, 1);
        chk("t6 data", {28'd0, last_out}, 32'b0001);

        // throughput: three frames with m_ready high take exactly 12 cycles
        o0 = out_cnt;
        c0 = cyc;
        for (int f = 0; f < 3; f++) send('{f, 20, -20, 100 + f, 0, 0, 0, 0}, 4);
        chk("tput cycles", cyc - c0, 12);
        idle(3);
        chk("tput outs", out_cnt - o0, 3);

        // randomized traffic with random backpressure, bad frames and resets
        rand_mr = 1;
        for (int f = 0; f < 300; f++) begin
            idle($urandom_range(0, 2));
            len = ($urandom_range(0, 9) < 7) ? N : $urandom_range(1, 7);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1)
                    rv[i] = thr[i % N] + $urandom_range(0, 2) - 1;
                else
                    rv[i] = $urandom_range(0, 255) - 128;
            end
            if ($urandom_range(0, 39) == 0) begin
                beat(rv[0], 0);
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            send(rv, len);
        end
        rand_mr = 0;
        m_ready = 1'b1;
        idle(5);
        @(negedge clk);
        chk("drain m_valid", {31'd0, m_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
